cfg_req_arb64: RTL and testbench

//  Shares one 64-bit config target port (rtlgen_pkg_v1 cfg_req_64bit_t/cfg_ack_64bit_t) among N_REQ requesters.

---
 rtl/cfg_req_arb64.sv | 107 ++++++++++
 tb/tb_cfg_req_arb64.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_req_arb64.sv
// Round-robin arbiter sharing one 64-bit config target among N_REQ requesters.
// One transaction in flight; watchdog synthesizes a miss if the target never acks.
module cfg_req_arb64 #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ*160-1:0] req_in,
  output logic [N_REQ*68-1:0]  ack_out,
  output logic [159:0]         req_out,
  input  logic [67:0]          ack_in,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int WD_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int VLD = 159;
  localparam int OP0 = 155;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                      state;
  logic [WD_W-1:0]             wd;
  logic [N_REQ-1:0][159:0]     req_a;
  logic [N_REQ-1:0][67:0]      ack_q;
  logic [N_REQ-1:0]            vld;
  logic                        found;
  logic [IDX_W-1:0]            pick;
  logic                        done;
  logic                        wd_hit;

  assign req_a   = req_in;
  assign ack_out = ack_q;
  assign busy    = (state != IDLE);
  assign done    = |ack_in[67:64];
  assign wd_hit  = (TIMEOUT_CYC != 0) && (wd == WD_W'(WD_LAST));

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      vld[i] = req_a[i][VLD];
    end
  end

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = grant_idx;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && vld[(int'(grant_idx) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(grant_idx) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_out     <= '0;
      ack_q       <= '0;
      grant_idx   <= IDX_W'(N_REQ - 1);
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack_q       <= '0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (found) begin
            grant_idx <= pick;
            req_out   <= req_a[pick];
            state     <= WAIT;
          end
        end
        WAIT: begin
          wd <= wd + 1'b1;
          if (done) begin
            ack_q[grant_idx] <= ack_in;
            req_out[VLD]     <= 1'b0;
            state            <= RESP;
          end else if (wd_hit) begin
            ack_q[grant_idx] <= {req_out[OP0], 1'b0,
                                 ~req_out[OP0], 1'b0, 64'h0};
            timeout_err      <= 1'b1;
            req_out[VLD]     <= 1'b0;
            state            <= RESP;
          end
        end
        RESP: begin
          wd    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_req_arb64.sv
// Bench for cfg_req_arb64: directed scenarios plus randomized traffic
// checked against a queue-free round-robin reference model.
module tb_cfg_req_arb64;

  localparam int N = 4;
  localparam int TO = 8;
  localparam logic [3:0] MRD = 4'h0;
  localparam logic [3:0] MWR = 4'h1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*160-1:0] req_in;
  logic [N*68-1:0]  ack_out;
  logic [159:0]   req_out;
  logic [67:0]    ack_in = '0;
  logic [1:0]     grant_idx;
  logic           busy;
  logic           timeout_err;

  logic [159:0]   rq [N];
  int             n_chk = 0;
  int             n_fail = 0;

  always #5 clk = ~clk;

  always_comb req_in = {rq[3], rq[2], rq[1], rq[0]};

  cfg_req_arb64 #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack_out),
    .req_out(req_out), .ack_in(ack_in), .grant_idx(grant_idx),
    .busy(busy), .timeout_err(timeout_err)
  );

  function automatic logic [159:0] mk_req(logic [3:0] op,
                                          logic [63:0] addr,
                                          logic [63:0] data);
    return {1'b1, op, 3'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), addr, data};
  endfunction

  function automatic logic [N*68-1:0] ack_vec(int g, logic [67:0] v);
    logic [N*68-1:0] r;
    r = '0;
    r[g*68 +: 68] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) rq[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if (req_out !== '0 || ack_out !== '0 || busy !== 1'b0 ||
        timeout_err !== 1'b0 || grant_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL reset: req_out=%h ack_out=%h busy=%b te=%b g=%0d",
               req_out, ack_out, busy, timeout_err, grant_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [67:0] a;
    rq[2] = mk_req(MRD, 64'h10, 64'h0);
    step();
    n_chk++;
    if (req_out !== rq[2] || grant_idx !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: req_out=%h g=%0d exp g=2 req=%h",
               req_out, grant_idx, rq[2]);
    end
    step();
    step();
    a = {4'b0001, 64'hDEAD};
    ack_in = a;
    step();
    ack_in = '0;
    rq[2] = '0;
    n_chk++;
    if (ack_out !== ack_vec(2, a) || req_out[159] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack_out=%h exp %h v=%b",
               ack_out, ack_vec(2, a), req_out[159]);
    end
    step();
    n_chk++;
    if (busy !== 1'b0 || ack_out !== '0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b ack_out=%h exp 0", busy, ack_out);
    end
  endtask

  task automatic test_round_robin();
    int last;
    int exp;
    logic [67:0] a;
    do_reset();
    last = N - 1;
    for (int i = 0; i < N; i++) rq[i] = mk_req(4'($urandom), 64'($urandom),
                                               64'($urandom));
    for (int n = 0; n < 5; n++) begin
      step();
      exp = (last + 1) % N;
      last = exp;
      n_chk++;
      if (grant_idx !== 2'(exp) || req_out !== rq[exp]) begin
        n_fail++;
        $display("FAIL rr_grant: g=%0d exp %0d", grant_idx, exp);
      end
      a = {4'(1 << $urandom_range(0, 3)), 64'($urandom)};
      ack_in = a;
      step();
      ack_in = '0;
      n_chk++;
      if (ack_out !== ack_vec(exp, a)) begin
        n_fail++;
        $display("FAIL rr_ack: ack_out=%h exp %h", ack_out, ack_vec(exp, a));
      end
      step();
    end
    clear_reqs();
    step();
  endtask

  task automatic test_timeout();
    int g;
    logic [3:0] op;
    logic [67:0] m;
    for (int t = 0; t < 2; t++) begin
      op = (t == 0) ? MWR : MRD;
      g = $urandom_range(0, N - 1);
      rq[g] = mk_req(op, 64'($urandom), 64'($urandom));
      step();
      repeat (TO - 1) begin
        step();
        n_chk++;
        if (timeout_err !== 1'b0 || ack_out !== '0 || req_out !== rq[g]) begin
          n_fail++;
          $display("FAIL to_early: te=%b ack_out=%h", timeout_err, ack_out);
        end
      end
      step();
      m = {op[0], 1'b0, ~op[0], 1'b0, 64'h0};
      n_chk++;
      if (timeout_err !== 1'b1 || ack_out !== ack_vec(g, m) ||
          req_out[159] !== 1'b0) begin
        n_fail++;
        $display("FAIL to_miss: te=%b ack_out=%h exp %h",
                 timeout_err, ack_out, ack_vec(g, m));
      end
      rq[g] = '0;
      ack_in = {4'b0100, 64'($urandom)};
      step();
      n_chk++;
      if (ack_out !== '0 || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL to_late: ack_out=%h te=%b exp 0", ack_out, timeout_err);
      end
      step();
      ack_in = '0;
      n_chk++;
      if (ack_out !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL to_idle: ack_out=%h busy=%b exp 0", ack_out, busy);
      end
    end
  endtask

  task automatic test_ack_vs_timeout();
    logic [67:0] a;
    rq[1] = mk_req(MWR, 64'($urandom), 64'($urandom));
    step();
    repeat (TO - 1) step();
    a = {4'b0100, 64'($urandom)};
    ack_in = a;
    step();
    ack_in = '0;
    rq[1] = '0;
    n_chk++;
    if (ack_out !== ack_vec(1, a) || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_vs_to: ack_out=%h te=%b exp %h te=0",
               ack_out, timeout_err, ack_vec(1, a));
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    rq[2] = mk_req(MRD, 64'($urandom), 64'($urandom));
    step();
    step();
    rst = 1'b1;
    #1;
    n_chk++;
    if (req_out[159] !== 1'b0 || busy !== 1'b0 || grant_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL rst_wait: v=%b busy=%b g=%0d exp 0 0 3",
               req_out[159], busy, grant_idx);
    end
    for (int i = 0; i < N; i++) rq[i] = mk_req(4'($urandom), 64'($urandom),
                                               64'($urandom));
    step();
    n_chk++;
    if (ack_out !== '0) begin
      n_fail++;
      $display("FAIL rst_noack: ack_out=%h exp 0", ack_out);
    end
    rst = 1'b0;
    step();
    n_chk++;
    if (grant_idx !== 2'd0 || req_out !== rq[0]) begin
      n_fail++;
      $display("FAIL rst_regrant: g=%0d exp 0", grant_idx);
    end
    ack_in = {4'b0001, 64'h0};
    step();
    ack_in = '0;
    clear_reqs();
    step();
  endtask

  task automatic test_spurious();
    repeat (4) begin
      ack_in = {4'($urandom_range(1, 15)), 64'($urandom)};
      step();
      n_chk++;
      if (ack_out !== '0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious: ack_out=%h busy=%b te=%b exp 0",
                 ack_out, busy, timeout_err);
      end
    end
    ack_in = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int last;
    int exp;
    int d;
    logic [67:0] a;
    do_reset();
    clear_reqs();
    mask = '0;
    last = N - 1;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!mask[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = mk_req(4'($urandom), 64'($urandom), 64'($urandom));
          mask[i] = 1'b1;
        end
      end
      step();
      if (mask == '0) begin
        n_chk++;
        if (busy !== 1'b0 || req_out[159] !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_idle: busy=%b v=%b", busy, req_out[159]);
        end
        continue;
      end
      exp = -1;
      for (int k = 1; k <= N && exp < 0; k++) begin
        if (mask[(last + k) % N]) exp = (last + k) % N;
      end
      last = exp;
      n_chk++;
      if (grant_idx !== 2'(exp) || req_out !== rq[exp] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_grant: g=%0d exp %0d mask=%b",
                 grant_idx, exp, mask);
      end
      d = $urandom_range(0, 5);
      repeat (d) step();
      n_chk++;
      if (req_out !== rq[exp] || ack_out !== '0) begin
        n_fail++;
        $display("FAIL rnd_hold: req_out=%h exp %h", req_out, rq[exp]);
      end
      a = {4'($urandom_range(1, 15)), 64'($urandom)};
      ack_in = a;
      step();
      ack_in = '0;
      rq[exp] = '0;
      mask[exp] = 1'b0;
      n_chk++;
      if (ack_out !== ack_vec(exp, a) || timeout_err !== 1'b0 ||
          req_out[159] !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_ack: ack_out=%h exp %h", ack_out, ack_vec(exp, a));
      end
      step();
      n_chk++;
      if (busy !== 1'b0 || ack_out !== '0) begin
        n_fail++;
        $display("FAIL rnd_resp: busy=%b ack_out=%h exp 0", busy, ack_out);
      end
    end
    clear_reqs();
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ack_vs_timeout();
    test_reset_mid_wait();
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
